// File: rtl/dht_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dht_pkg
// Description : Shared types and constants for the DHT11 read scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dht_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } dht_state_e;

  // {hum_int, hum_dec, temp_int, temp_dec}
  localparam int DHT_DATA_W = 32;

  // 2 s between sensor reads at 50 MHz
  localparam int DHT_MIN_GAP_CYC_DFLT = 100_000_000;
  // 100 ms ceiling on a single read at 50 MHz
  localparam int DHT_TIMEOUT_CYC_DFLT = 5_000_000;

endpackage
`default_nettype wire

// File: rtl/dht_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : dht_gap_timer
// Description : Saturating up-counter that flags when the minimum spacing
//               between sensor reads has elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
module dht_gap_timer #(
  parameter int MAX_CYC = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic sat
);

  localparam int             W       = $clog2(MAX_CYC + 1);
  localparam logic [W-1:0]   MAX_VAL = W'(MAX_CYC);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over counting; counting stops once the ceiling is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register; reset starts the sensor power-on wait
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == MAX_VAL);

endmodule
`default_nettype wire

// File: rtl/dht_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dht_read_scheduler
// Description : Arbitrates several requesters onto one DHT11 reader. Reads
//               are spaced by MIN_GAP_CYC, bounded by TIMEOUT_CYC, and every
//               requester pending when a read finishes is answered by it.
//               Optional macro DHT_CACHE_EN: requests arriving while the gap
//               has not elapsed are answered from the last good read.
// Revision    : 1.0 - initial release
// ============================================================================
module dht_read_scheduler
  import dht_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MIN_GAP_CYC = DHT_MIN_GAP_CYC_DFLT,
  parameter int TIMEOUT_CYC = DHT_TIMEOUT_CYC_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DHT_DATA_W-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  rsp_cached,
  output logic                  rd_start,
  input  logic                  rd_busy,
  input  logic                  rd_done,
  input  logic                  rd_err,
  input  logic [DHT_DATA_W-1:0] rd_data
);

  localparam int              TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  dht_state_e            state_q, state_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  // rsp_data doubles as the cache: it always holds the last captured read
  logic [DHT_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  gap_ok;
  logic                  gap_clr;
  logic                  gap_en;
`ifdef DHT_CACHE_EN
  logic                  cache_valid_q, cache_valid_d;
  logic                  rsp_cached_q, rsp_cached_d;
`endif

  // The sensor spacing only advances while no read is outstanding
  assign gap_en = (state_q != S_WAIT);

  dht_gap_timer #(
    .MAX_CYC (MIN_GAP_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (gap_clr),
    .en    (gap_en),
    .sat   (gap_ok)
  );

  // Next-state, timeout counting and response capture
  always_comb begin
    state_d       = state_q;
    to_cnt_d      = '0;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    gap_clr       = 1'b0;
`ifdef DHT_CACHE_EN
    cache_valid_d = cache_valid_q;
    rsp_cached_d  = rsp_cached_q;
`endif
    case (state_q)
      S_IDLE: begin
        if ((|req) && gap_ok && !rd_busy) begin
          state_d = S_START;
`ifdef DHT_CACHE_EN
        end else if ((|req) && !gap_ok && cache_valid_q) begin
          state_d      = S_RESP;
          rsp_err_d    = 1'b0;
          rsp_cached_d = 1'b1;
`endif
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completed read beats a timeout expiring in the same cycle
        if (rd_done) begin
          rsp_data_d    = rd_data;
          rsp_err_d     = rd_err;
          gap_clr       = 1'b1;
          state_d       = S_RESP;
`ifdef DHT_CACHE_EN
          cache_valid_d = !rd_err;
          rsp_cached_d  = 1'b0;
`endif
        end else if (to_cnt_q == TO_MAX) begin
          rsp_err_d     = 1'b1;
          gap_clr       = 1'b1;
          state_d       = S_RESP;
`ifdef DHT_CACHE_EN
          rsp_cached_d  = 1'b0;
`endif
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      to_cnt_q      <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
`ifdef DHT_CACHE_EN
      cache_valid_q <= 1'b0;
      rsp_cached_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
`ifdef DHT_CACHE_EN
      cache_valid_q <= cache_valid_d;
      rsp_cached_q  <= rsp_cached_d;
`endif
    end
  end

  // Only requesters still asserting in the response cycle are acknowledged
  assign ack      = (state_q == S_RESP) ? req : '0;
  assign rd_start = (state_q == S_START);
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
`ifdef DHT_CACHE_EN
  assign rsp_cached = rsp_cached_q;
`else
  assign rsp_cached = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dht_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dht_read_scheduler
// Description : Self-checking bench for dht_read_scheduler: directed read
//               table, cache/reset sequences and a randomized run against a
//               cycle model built from the scheduling rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dht_read_scheduler;

  localparam int MIN_GAP = 100;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  ack;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_cached;
  logic        rd_start;
  logic        rd_busy = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_err = 1'b0;
  logic [31:0] rd_data = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dht_read_scheduler #(
    .NUM_REQ     (2),
    .MIN_GAP_CYC (MIN_GAP),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .ack        (ack),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_cached (rsp_cached),
    .rd_start   (rd_start),
    .rd_busy    (rd_busy),
    .rd_done    (rd_done),
    .rd_err     (rd_err),
    .rd_data    (rd_data)
  );

  // done_at: WAIT cycle index carrying rd_done, -1 = withhold (timeout)
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  req_late;
    int          done_at;
    logic        err;
    logic [31:0] data;
    int          busy_hold;
    logic [1:0]  exp_ack;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[7];

  // ---------------- reference model ----------------
  int          m_gap;
  int          m_wait_cyc;
  bit          m_start, m_wait, m_resp;
  logic [31:0] m_data;
  logic        m_err, m_cached;
  bit          m_cache_ok;

  function automatic void model_reset();
    m_gap = 0; m_wait_cyc = 0;
    m_start = 0; m_wait = 0; m_resp = 0;
    m_data = '0; m_err = 0; m_cached = 0; m_cache_ok = 0;
  endfunction

  function automatic void model_step(input logic [1:0] r, input logic busy,
                                     input logic done, input logic err,
                                     input logic [31:0] data);
    bit ns = 0, nw = 0, nr = 0;
    int gap_n = m_gap;
    if (!m_wait) gap_n = (m_gap < MIN_GAP) ? m_gap + 1 : MIN_GAP;
    if (m_start) begin
      nw = 1; m_wait_cyc = 0;
    end else if (m_wait) begin
      if (done) begin
        m_data = data; m_err = err; m_cached = 0; m_cache_ok = !err;
        gap_n = 0; nr = 1;
      end else if (m_wait_cyc == TIMEOUT) begin
        m_err = 1; m_cached = 0; gap_n = 0; nr = 1;
      end else begin
        nw = 1; m_wait_cyc++;
      end
    end else if (!m_resp) begin
      if (r != 0 && m_gap == MIN_GAP && !busy) ns = 1;
`ifdef DHT_CACHE_EN
      else if (r != 0 && m_gap != MIN_GAP && m_cache_ok) begin
        nr = 1; m_err = 0; m_cached = 1;
      end
`endif
    end
    m_gap = gap_n; m_start = ns; m_wait = nw; m_resp = nr;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Counts cycles until rd_start; a stray rd_done is injected on the way
  task automatic wait_start(input int limit, input int busy_hold, input int req_at,
                            input logic [1:0] req_val, output int n);
    n = 0;
    if (req_at == 0) req = req_val;
    while (!rd_start && n < limit) begin
      tick();
      n++;
      if (n == req_at) req = req_val;
      if (busy_hold > 0 && n == busy_hold) rd_busy = 1'b0;
      if (n == 5) begin
        rd_done = 1'b1; rd_err = 1'b1; rd_data = 32'hDEAD_BEEF;
      end else if (n == 6) begin
        rd_done = 1'b0; rd_err = 1'b0;
      end
    end
    rd_done = 1'b0; rd_err = 1'b0;
    if (!rd_start) n = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_n;
    int late_req;
`ifdef DHT_CACHE_EN
    late_req = MIN_GAP;
`else
    late_req = 0;
`endif
    //        req    late   done  err   data           busy  ack    err   data
    tbl[0] = '{2'b01, 2'b01, 3,  1'b0, 32'h3700_1A05, 0,   2'b01, 1'b0, 32'h3700_1A05};
    tbl[1] = '{2'b10, 2'b11, 5,  1'b0, 32'h3800_1B06, 0,   2'b11, 1'b0, 32'h3800_1B06};
    tbl[2] = '{2'b01, 2'b01, -1, 1'b0, 32'h0000_0000, 0,   2'b01, 1'b1, 32'h3800_1B06};
    tbl[3] = '{2'b11, 2'b11, 50, 1'b1, 32'h1234_5678, 0,   2'b11, 1'b1, 32'h1234_5678};
    tbl[4] = '{2'b10, 2'b10, 50, 1'b0, 32'h3900_0000, 0,   2'b10, 1'b0, 32'h3900_0000};
    tbl[5] = '{2'b01, 2'b00, 2,  1'b0, 32'hAABB_CCDD, 0,   2'b00, 1'b0, 32'hAABB_CCDD};
    tbl[6] = '{2'b10, 2'b10, 0,  1'b0, 32'h4000_0102, 120, 2'b10, 1'b0, 32'h4000_0102};

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    check("reset_ack", {30'd0, ack}, 32'd0);
    check("reset_rd_start", {31'd0, rd_start}, 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset_rsp_cached", {31'd0, rsp_cached}, 32'd0);
    rst_n = 1'b1;

    // Directed read table
    for (int i = 0; i < 7; i++) begin
      rd_busy = (tbl[i].busy_hold > 0);
      wait_start(400, tbl[i].busy_hold, (i == 0) ? 0 : late_req, tbl[i].req, n);
      exp_n = (tbl[i].busy_hold + 1 > MIN_GAP + 1) ? tbl[i].busy_hold + 1 : MIN_GAP + 1;
      check($sformatf("v%0d_start_cycle", i), n, exp_n);
      tick();
      req = tbl[i].req_late;
      if (tbl[i].done_at >= 0) begin
        repeat (tbl[i].done_at) tick();
        rd_done = 1'b1; rd_err = tbl[i].err; rd_data = tbl[i].data;
        tick();
        rd_done = 1'b0; rd_err = 1'b0;
      end else begin
        repeat (TIMEOUT) tick();
        check($sformatf("v%0d_no_early_ack", i), {30'd0, ack}, 32'd0);
        tick();
      end
      check($sformatf("v%0d_ack", i), {30'd0, ack}, {30'd0, tbl[i].exp_ack});
      if (tbl[i].exp_ack != 2'b00) begin
        check($sformatf("v%0d_rsp_data", i), rsp_data, tbl[i].exp_data);
        check($sformatf("v%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, tbl[i].exp_err});
        check($sformatf("v%0d_rsp_cached", i), {31'd0, rsp_cached}, 32'd0);
      end
      req = 2'b00;
    end

    // Request arriving 10 cycles after a good read
    repeat (10) tick();
    req = 2'b01;
`ifdef DHT_CACHE_EN
    tick();
    check("cache_ack", {30'd0, ack}, 32'd1);
    check("cache_rsp_cached", {31'd0, rsp_cached}, 32'd1);
    check("cache_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("cache_rsp_data", rsp_data, 32'h4000_0102);
    check("cache_no_start", {31'd0, rd_start}, 32'd0);
    wait_start(400, 0, 0, 2'b01, n);
    check("cache_then_start", {31'd0, rd_start}, 32'd1);
`else
    wait_start(400, 0, 0, 2'b01, n);
    check("nocache_start_cycle", n, MIN_GAP + 1 - 10);
`endif

    // Reset in the middle of a read
    tick();
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("wait_reset_ack", {30'd0, ack}, 32'd0);
    check("wait_reset_rd_start", {31'd0, rd_start}, 32'd0);
    check("wait_reset_rsp_data", rsp_data, 32'd0);
    check("wait_reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("wait_reset_rsp_cached", {31'd0, rsp_cached}, 32'd0);
    rst_n = 1'b1;
    wait_start(400, 0, 0, 2'b01, n);
    check("post_reset_start_cycle", n, MIN_GAP + 1);
    tick();
    tick();
    rd_done = 1'b1; rd_err = 1'b0; rd_data = 32'h5555_AAAA;
    tick();
    rd_done = 1'b0;
    check("post_reset_ack", {30'd0, ack}, 32'd1);
    check("post_reset_rsp_data", rsp_data, 32'h5555_AAAA);
    check("post_reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    req = 2'b00;

    // Randomized run against the model
    rst_n = 1'b0;
    rd_busy = 1'b0;
    tick(); tick();
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (!req[b] && $urandom_range(29) == 0) req[b] = 1'b1;
        else if (req[b] && $urandom_range(199) == 0) req[b] = 1'b0;
      end
      if ($urandom_range(49) == 0) rd_busy = ~rd_busy;
      rd_done = ($urandom_range(24) == 0);
      rd_err  = ($urandom_range(3) == 0);
      rd_data = $urandom;
      tick();
      model_step(req, rd_busy, rd_done, rd_err, rd_data);
      check("rnd_rd_start", {31'd0, rd_start}, {31'd0, m_start});
      check("rnd_ack", {30'd0, ack}, m_resp ? {30'd0, req} : 32'd0);
      if (m_resp && req != 2'b00) begin
        check("rnd_rsp_data", rsp_data, m_data);
        check("rnd_rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        check("rnd_rsp_cached", {31'd0, rsp_cached}, {31'd0, m_cached});
      end
      req = req & ~ack;
    end
    rd_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
